// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing generator: 720p60 default raster,
// sync polarity constants, controller state type and the colour-bar table
// used by the optional test pattern (VTG_TEST_PATTERN_EN).
package video_timing_pkg;

  // 1280x720@60, 74.25 MHz pixel clock
  localparam int unsigned DEF_H_ACTIVE = 1280;
  localparam int unsigned DEF_H_FP     = 110;
  localparam int unsigned DEF_H_SYNC   = 40;
  localparam int unsigned DEF_H_BP     = 220;
  localparam int unsigned DEF_V_ACTIVE = 720;
  localparam int unsigned DEF_V_FP     = 5;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 20;

  localparam bit POL_HIGH = 1'b1;
  localparam bit POL_LOW  = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vtg_state_e;

  // Eight vertical bars, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black. Returned as {red, green, blue}.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    c = '0;
    case (idx)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the video timing generator: run control, FIFO
// request/data, sync/de/rgb towards the TMDS encoder and underflow status.
// pattern_sel exists only when VTG_TEST_PATTERN_EN is defined.
interface video_timing_gen_if;
  logic        enable;
  logic [23:0] rgb_in;
  logic        rgb_valid;
  logic        underflow_clr;
`ifdef VTG_TEST_PATTERN_EN
  logic        pattern_sel;
`endif
  logic        data_req;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic        underflow;

  // Generator side
  modport master (
`ifdef VTG_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    input  enable, rgb_in, rgb_valid, underflow_clr,
    output data_req, hsync, vsync, de, red, green, blue, frame_start, underflow
  );

  // Consumer / FIFO side
  modport slave (
`ifdef VTG_TEST_PATTERN_EN
    output pattern_sel,
`endif
    output enable, rgb_in, rgb_valid, underflow_clr,
    input  data_req, hsync, vsync, de, red, green, blue, frame_start, underflow
  );
endinterface

// File: rtl/video_sync_counter.sv
// Raster position counters for the video timing generator. Counters hold at
// zero while run is low and wrap at the frame totals; region flags and the
// end-of-frame flag are decoded combinationally from the current position.
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_active,
  output logic          v_active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          eof
);

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  // Position counters: h wraps every line, v advances on the h wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Region decode; v_cnt only moves at h_cnt = 0, so v_sync does too
  always_comb begin
    h_active = (h_cnt < HW'(H_ACTIVE));
    v_active = (v_cnt < VW'(V_ACTIVE));
    h_sync   = (h_cnt >= HW'(H_ACTIVE + H_FP)) &&
               (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    v_sync   = (v_cnt >= VW'(V_ACTIVE + V_FP)) &&
               (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
    eof      = h_last && v_last;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: raster controller, two-stage sync/de pipeline and
// pixel request/return path feeding the TMDS encoder. data_req leads de by
// one clock; sync/de/frame_start lag the counters by two clocks.
// Optional colour-bar test pattern under VTG_TEST_PATTERN_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = POL_HIGH,
  parameter bit          VS_POL   = POL_HIGH
) (
  input  logic               pixelclk,
  input  logic               rstin,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  vtg_state_e    state_q, state_d;
  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_active, v_active, h_sync, v_sync, eof;
  logic          pattern_on;

  logic          req_s1, de_s1, hs_s1, vs_s1, fs_s1;
  logic          req_s2, de_s2, hs_s2, vs_s2, fs_s2;
  logic [23:0]   rgb_out;
  logic          uf_set;

  video_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clk      (pixelclk),
    .rst      (rstin),
    .run      (run),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_active (h_active),
    .v_active (v_active),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .eof      (eof)
  );

  // Controller state register
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Start/stop only at frame boundaries; a drop of enable on the very last
  // pixel ends the frame straight into IDLE
  always_comb begin
    state_d = state_q;
    run     = (state_q != IDLE);
    unique case (state_q)
      IDLE:     if (vid.enable) state_d = RUN;
      RUN:      if (!vid.enable) state_d = eof ? IDLE : STOPPING;
      STOPPING: if (vid.enable) state_d = RUN;
                else if (eof)   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef VTG_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [2:0] bar_s1, bar_s2;

  // Pattern select is latched while idle and at the last pixel of a frame
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin)                        pattern_on <= 1'b0;
    else if (state_q == IDLE || eof)  pattern_on <= vid.pattern_sel;
  end

  // Bar index follows the same two-stage lag as de
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin) begin
      bar_s1 <= '0;
      bar_s2 <= '0;
    end else begin
      bar_s1 <= 3'(h_cnt / HW'(BAR_W));
      bar_s2 <= bar_s1;
    end
  end
`else
  assign pattern_on = 1'b0;
`endif

  // Stage 1: request and raw timing from the counters
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin) begin
      req_s1 <= 1'b0;
      de_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      fs_s1  <= 1'b0;
    end else begin
      req_s1 <= h_active & v_active & run & ~pattern_on;
      de_s1  <= h_active & v_active & run;
      hs_s1  <= h_sync & run;
      vs_s1  <= v_sync & run;
      fs_s1  <= run & (h_cnt == '0) & (v_cnt == '0);
    end
  end

  // Stage 2: output timing plus the request that the current rgb_in answers
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin) begin
      req_s2 <= 1'b0;
      de_s2  <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
      fs_s2  <= 1'b0;
    end else begin
      req_s2 <= req_s1;
      de_s2  <= de_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      fs_s2  <= fs_s1;
    end
  end

  // rgb_in arrives in the same cycle as de (one clock after data_req), so
  // the pixel is selected against the registered request rather than
  // re-registered, keeping it aligned with de without an extra stage.
`ifdef VTG_TEST_PATTERN_EN
  assign rgb_out = (de_s2 && pattern_on)     ? bar_colour(bar_s2) :
                   (req_s2 && vid.rgb_valid) ? vid.rgb_in : '0;
`else
  assign rgb_out = (req_s2 && vid.rgb_valid) ? vid.rgb_in : '0;
`endif

  assign uf_set = req_s2 & ~vid.rgb_valid;

  // Sticky underflow; a set in the same cycle as a clear wins
  always_ff @(posedge pixelclk or posedge rstin) begin
    if (rstin)                  vid.underflow <= 1'b0;
    else if (uf_set)            vid.underflow <= 1'b1;
    else if (vid.underflow_clr) vid.underflow <= 1'b0;
  end

  assign vid.data_req    = req_s1;
  assign vid.de          = de_s2;
  assign vid.hsync       = HS_POL ? hs_s2 : ~hs_s2;
  assign vid.vsync       = VS_POL ? vs_s2 : ~vs_s2;
  assign vid.frame_start = fs_s2;
  assign vid.red         = rgb_out[23:16];
  assign vid.green       = rgb_out[15:8];
  assign vid.blue        = rgb_out[7:0];

endmodule
